tbird_light_seq: RTL and testbench
==================================

Name: tbird_light_seq

Overview:
- Parametrised successor to the fixed 3+3 Thunderbird tail-light pair: one block drives LAMPS lamps per side.
- Adds the per-step clock divider, hazard mode and a brake overlay.
- Sits between the switch/debounce logic and the LED pins on the board top level, and replaces the separate divider plus per-side sequencer instances.
- All lamp outputs are registered in the single `clk` domain.

Parameters:
- LAMPS, 3, lamps per side; legal range 1..16.
- DIV, 50000000, `clk` cycles per sequence step; legal range >=1. DIV=1 steps every cycle.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- left  in  1  left turn request, level.
- right  in  1  right turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake pedal, level.
- lamps_l  out  LAMPS  left lamps; bit 0 innermost, bit LAMPS-1 outermost.
- lamps_r  out  LAMPS  right lamps; bit 0 innermost, bit LAMPS-1 outermost.
- step_tick  out  1  one-cycle strobe marking each sequence step (debug/bench).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, step=0, div_cnt=0.
  - lamps_l=0, lamps_r=0, step_tick=0.
  - rst mid-sequence aborts immediately; no partial pattern is held.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - tick is asserted internally when div_cnt==DIV-1.
  - step_tick is the tick registered one cycle, so it pulses once per DIV cycles.
- Requested mode (combinational), in priority order:
  - hazard=1 or (left=1 and right=1) -> HAZ.
  - else left=1 -> LEFT.
  - else right=1 -> RIGHT.
  - else IDLE.
- State machine with states IDLE, LEFT, RIGHT, HAZ:
  - Any cycle where the requested mode differs from state: state<=requested, step<=0, div_cnt<=0. The change takes effect on the next edge; there is no waiting for a tick.
  - Otherwise, on tick:
    - LEFT/RIGHT: step<=(step==LAMPS)?0:step+1.
    - HAZ: step<=step^1 (values 0/1).
    - IDLE: step holds at 0.
  - step width is clog2(LAMPS+1).
- Pattern, where the thermometer therm(k) has bits [k-1:0] set:
  - LEFT: active side = therm(step), so step 0 is all off and step LAMPS is all on. Full cycle is LAMPS+1 steps.
  - RIGHT: same, mirrored onto lamps_r.
  - HAZ: both sides all-ones when step==1, all-zeros when step==0.
- Brake overlay:
  - Any side not actively sequencing (both sides in IDLE, the right side in LEFT, the left side in RIGHT) is forced to all-ones while brake=1.
  - The sequencing side ignores brake.
  - HAZ ignores brake entirely.
- Output timing:
  - lamps_l/lamps_r are registered from (state, step, brake).
  - Brake latency: 1 cycle.
  - A step change is visible 1 cycle after the edge that updates step.
- Boundaries:
  - left and right both set is treated as HAZ, never as two independent sequences.
  - Dropping a request mid-sequence returns to IDLE with lamps off (or brake-lit) on the next edge.
  - Reasserting the request restarts at step 0.
  - LAMPS=1: the sequence alternates 0/1, the same as a single blinker.

Test Plan (LAMPS=3, DIV=4 unless stated):
- Reset: apply rst for 2 cycles with left=1 -> lamps_l=000, lamps_r=000, step_tick=0 throughout. After release, state enters LEFT on the first edge.
- Left sequence: hold left=1 -> lamps_l steps 000,001,011,111,000 with exactly 4 cycles between changes; lamps_r stays 000; step_tick pulses once per 4 cycles.
- Hazard: set left=1 and right=1 together -> both sides toggle 000/111 every 4 cycles, in phase. Repeating with hazard=1 alone gives the identical waveform.
- Brake overlay: right=1 with brake=1 -> lamps_l=111 one cycle after brake rises while lamps_r sequences normally. Brake in IDLE -> both 111. Brake during HAZ -> no effect.
- Mid-sequence abort: drop left at lamps_l=011 -> lamps_l=000 on the next edge. Reasserting left restarts at 000, and 001 appears 4 cycles later.
- Parameter sweep: LAMPS=1, DIV=1 -> lamps_l toggles 0/1 every cycle. LAMPS=8, DIV=2 -> 9-step thermometer ending at 0xFF, then 0x00.

Source files
------------

// File: rtl/tbird_light_seq.sv
// Thunderbird-style tail-light sequencer with LAMPS lamps per side.
// A built-in divider produces one sequence step every DIV clk cycles. Turn
// requests run a thermometer fill on their side, hazard (or left+right)
// blinks both sides in phase, and brake lights any side that is not
// currently sequencing.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   left       left turn request (level)
//   right      right turn request (level)
//   hazard     hazard request (level)
//   brake      brake pedal (level)
//   lamps_l    left lamps, bit 0 innermost, registered
//   lamps_r    right lamps, bit 0 innermost, registered
//   step_tick  one-cycle strobe per sequence step, registered
module tbird_light_seq #(
    parameter int unsigned LAMPS = 3,
    parameter int unsigned DIV   = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] lamps_l,
    output logic [LAMPS-1:0] lamps_r,
    output logic             step_tick
);

    localparam int unsigned STEP_W = $clog2(LAMPS + 1);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [LAMPS-1:0]  ALL_ON    = {LAMPS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2,
        S_HAZ   = 2'd3
    } state_t;

    state_t            state, state_n, req_c;
    logic [STEP_W-1:0] step, step_n;
    logic [DIV_W-1:0]  div_cnt, div_cnt_n;
    logic              tick_c;
    logic [LAMPS-1:0]  lamps_l_n, lamps_r_n;

    // Thermometer code: lowest k bits set.
    function automatic logic [LAMPS-1:0] therm(input logic [STEP_W-1:0] k);
        logic [LAMPS-1:0] t;
        t = '0;
        for (int i = 0; i < int'(LAMPS); i++) begin
            t[i] = (i < int'(k));
        end
        return t;
    endfunction

    // Requested mode; both turn signals together collapse into hazard.
    always_comb begin
        req_c = S_IDLE;
        if (hazard || (left && right)) begin
            req_c = S_HAZ;
        end else if (left) begin
            req_c = S_LEFT;
        end else if (right) begin
            req_c = S_RIGHT;
        end
    end

    assign tick_c = (div_cnt == DIV_LAST);

    // Next-state, step, divider and lamp pattern.
    always_comb begin
        state_n   = state;
        step_n    = step;
        div_cnt_n = tick_c ? '0 : div_cnt + DIV_W'(1);
        lamps_l_n = '0;
        lamps_r_n = '0;

        // A mode change restarts the sequence and the divider immediately.
        if (req_c != state) begin
            state_n   = req_c;
            step_n    = '0;
            div_cnt_n = '0;
        end else if (tick_c) begin
            case (state)
                S_LEFT, S_RIGHT: step_n = (step == STEP_LAST) ? '0 : step + STEP_ONE;
                S_HAZ:           step_n = step ^ STEP_ONE;
                default:         step_n = '0;
            endcase
        end

        // Pattern from the current registered state; brake lights idle sides only.
        case (state)
            S_LEFT: begin
                lamps_l_n = therm(step);
                lamps_r_n = brake ? ALL_ON : '0;
            end
            S_RIGHT: begin
                lamps_l_n = brake ? ALL_ON : '0;
                lamps_r_n = therm(step);
            end
            S_HAZ: begin
                lamps_l_n = step[0] ? ALL_ON : '0;
                lamps_r_n = step[0] ? ALL_ON : '0;
            end
            default: begin
                lamps_l_n = brake ? ALL_ON : '0;
                lamps_r_n = brake ? ALL_ON : '0;
            end
        endcase
    end

    // State, divider and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            step      <= '0;
            div_cnt   <= '0;
            lamps_l   <= '0;
            lamps_r   <= '0;
            step_tick <= 1'b0;
        end else begin
            state     <= state_n;
            step      <= step_n;
            div_cnt   <= div_cnt_n;
            lamps_l   <= lamps_l_n;
            lamps_r   <= lamps_r_n;
            step_tick <= tick_c;
        end
    end

endmodule

// File: tb/tb_tbird_light_seq.sv
// Directed bench for tbird_light_seq: main instance LAMPS=3/DIV=4 plus
// LAMPS=1/DIV=1 and LAMPS=8/DIV=2 instances sharing the same inputs.
module tb_tbird_light_seq;

    logic       clk;
    logic       rst;
    logic       left;
    logic       right;
    logic       hazard;
    logic       brake;
    logic [2:0] lamps_l;
    logic [2:0] lamps_r;
    logic       step_tick;
    logic [0:0] l1_l;
    logic [0:0] l1_r;
    logic       l1_tick;
    logic [7:0] l8_l;
    logic [7:0] l8_r;
    logic       l8_tick;

    int total;
    int bad;

    tbird_light_seq #(.LAMPS(3), .DIV(4)) u_dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .lamps_l(lamps_l), .lamps_r(lamps_r), .step_tick(step_tick)
    );

    tbird_light_seq #(.LAMPS(1), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .lamps_l(l1_l), .lamps_r(l1_r), .step_tick(l1_tick)
    );

    tbird_light_seq #(.LAMPS(8), .DIV(2)) u_dut8 (
        .clk(clk), .rst(rst), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .lamps_l(l8_l), .lamps_r(l8_r), .step_tick(l8_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with the given inputs held, then expect the in-phase hazard blink.
    task automatic run_haz(input logic l, input logic r, input logic h, input logic b);
        logic [31:0] prev;
        logic [31:0] nxt;
        rst = 1'b1; left = l; right = r; hazard = h; brake = b;
        cyc(2);
        check("haz_rst_l", 32'(lamps_l), 32'h0);
        rst = 1'b0;
        cyc(2);
        check("haz_start_l", 32'(lamps_l), 32'h0);
        check("haz_start_r", 32'(lamps_r), 32'h0);
        prev = 32'h0;
        for (int i = 0; i < 4; i++) begin
            nxt = (i % 2 == 0) ? 32'h7 : 32'h0;
            cyc(3);
            check("haz_hold_l", 32'(lamps_l), prev);
            cyc(1);
            check("haz_step_l", 32'(lamps_l), nxt);
            check("haz_step_r", 32'(lamps_r), nxt);
            prev = nxt;
        end
    endtask

    initial begin
        logic [31:0] exp_seq [5];
        logic [31:0] prev;
        total = 0;
        bad   = 0;
        rst = 1'b1; left = 1'b1; right = 1'b0; hazard = 1'b0; brake = 1'b0;

        // Reset held two cycles with left requested.
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            check("rst_lamps_l", 32'(lamps_l), 32'h0);
            check("rst_lamps_r", 32'(lamps_r), 32'h0);
            check("rst_tick", 32'(step_tick), 32'h0);
        end
        rst = 1'b0;

        // Left sequence: first edge enters LEFT, pattern changes every 4 cycles.
        cyc(2);
        check("left_init", 32'(lamps_l), 32'h0);
        check("left_init_tick", 32'(step_tick), 32'h0);
        exp_seq[0] = 32'h1; exp_seq[1] = 32'h3; exp_seq[2] = 32'h7;
        exp_seq[3] = 32'h0; exp_seq[4] = 32'h1;
        prev = 32'h0;
        for (int i = 0; i < 5; i++) begin
            cyc(3);
            check("left_hold", 32'(lamps_l), prev);
            check("left_tick_hi", 32'(step_tick), 32'h1);
            cyc(1);
            check("left_step", 32'(lamps_l), exp_seq[i]);
            check("left_r_off", 32'(lamps_r), 32'h0);
            check("left_tick_lo", 32'(step_tick), 32'h0);
            prev = exp_seq[i];
        end

        // Mid-sequence abort at 011, then restart from step 0.
        cyc(4);
        check("abort_pre", 32'(lamps_l), 32'h3);
        left = 1'b0;
        cyc(2);
        check("abort_off", 32'(lamps_l), 32'h0);
        left = 1'b1;
        cyc(2);
        check("restart_0", 32'(lamps_l), 32'h0);
        cyc(3);
        check("restart_hold", 32'(lamps_l), 32'h0);
        cyc(1);
        check("restart_1", 32'(lamps_l), 32'h1);

        // Hazard via left+right, via hazard alone, and with brake pressed.
        run_haz(1'b1, 1'b1, 1'b0, 1'b0);
        run_haz(1'b0, 1'b0, 1'b1, 1'b0);
        run_haz(1'b0, 1'b0, 1'b1, 1'b1);

        // Brake overlay while the right side sequences.
        rst = 1'b1; left = 1'b0; right = 1'b1; hazard = 1'b0; brake = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check("brk_pre_l", 32'(lamps_l), 32'h0);
        brake = 1'b1;
        cyc(1);
        check("brk_on_l", 32'(lamps_l), 32'h7);
        check("brk_on_r", 32'(lamps_r), 32'h0);
        cyc(3);
        check("brk_seq_r", 32'(lamps_r), 32'h1);
        check("brk_seq_l", 32'(lamps_l), 32'h7);
        brake = 1'b0;
        cyc(1);
        check("brk_off_l", 32'(lamps_l), 32'h0);
        // Brake with no request: both sides lit once IDLE is reached.
        right = 1'b0;
        brake = 1'b1;
        cyc(2);
        check("brk_idle_l", 32'(lamps_l), 32'h7);
        check("brk_idle_r", 32'(lamps_r), 32'h7);
        brake = 1'b0;
        cyc(1);
        check("brk_rel_l", 32'(lamps_l), 32'h0);
        check("brk_rel_r", 32'(lamps_r), 32'h0);

        // Parameter sweep: LAMPS=1/DIV=1 and LAMPS=8/DIV=2.
        rst = 1'b1; left = 1'b1; right = 1'b0; hazard = 1'b0; brake = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check("l1_init", 32'(l1_l), 32'h0);
        check("l8_init", 32'(l8_l), 32'h0);
        for (int i = 1; i <= 9; i++) begin
            cyc(1);
            check("l1_on", 32'(l1_l), 32'h1);
            cyc(1);
            check("l1_off", 32'(l1_l), 32'h0);
            check("l1_r", 32'(l1_r), 32'h0);
            check("l8_step", 32'(l8_l), (i == 9) ? 32'h0 : ((32'h1 << i) - 32'h1));
            check("l8_r", 32'(l8_r), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
